// File: rtl/bws_pkg.sv
// Shared types and elaboration helpers for the wide-to-narrow bus serializer.
package bws_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  function automatic int unsigned slice_ratio(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit cfg_ok(input int unsigned in_w, input int unsigned out_w,
                                input int unsigned depth);
    return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/bws_fifo.sv
// Synchronous word FIFO with occupancy count; push on full and pop on empty are ignored.
module bws_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         din_i,
  output logic [Width-1:0]         dout_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CntW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_width_serializer.sv
// Buffers IN_W-bit words and emits them as OUT_W-bit slices with backpressure
// and a packet-end marker on the last slice of every PKT_WORDS-th word.
module bus_width_serializer
  import bws_pkg::*;
#(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PKT_WORDS = 4,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                     clkC,
  input  logic                     reset,
  input  logic [IN_W-1:0]          sharedBusBC,
  input  logic                     readyB,
  output logic                     acceptedC,
  output logic [OUT_W-1:0]         sharedBusCD,
  output logic                     readyC,
  input  logic                     acceptedD,
  output logic                     lastC,
  output logic [$clog2(DEPTH):0]   countC
);

  localparam int unsigned R    = slice_ratio(IN_W, OUT_W);
  localparam int unsigned IdxW = idx_width(R);
  localparam int unsigned PktW = idx_width(PKT_WORDS);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  if (!cfg_ok(IN_W, OUT_W, DEPTH)) begin : g_cfg_err
    $error("bus_width_serializer: IN_W must be a multiple (>=2x) of OUT_W, DEPTH a power of 2");
  end

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [PktW-1:0]  pkt_q, pkt_d;
  logic [IN_W-1:0]  shreg_q, shreg_d;

  logic [IN_W-1:0]  fifo_dout;
  logic [CntW-1:0]  fifo_count;
  logic             push, pop, xfer;
  logic             slice_last, pkt_last;
  logic [IdxW-1:0]  sel;
  logic [OUT_W-1:0] slices [R];

  bws_fifo #(
    .Width (IN_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clkC),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (sharedBusBC),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  for (genvar g = 0; g < R; g++) begin : g_slice
    assign slices[g] = shreg_q[g*OUT_W +: OUT_W];
  end

  // No credit for a same-cycle pop: a full FIFO refuses even while draining.
  assign acceptedC  = !reset && (fifo_count < CntW'(DEPTH));
  assign push       = readyB && acceptedC;
  assign countC     = fifo_count;

  assign readyC     = (state_q == StShift);
  assign xfer       = readyC && acceptedD;
  assign slice_last = (idx_q == IdxW'(R - 1));
  assign pkt_last   = (pkt_q == PktW'(PKT_WORDS - 1));
  assign sel        = (MSB_FIRST != 0) ? IdxW'(R - 1) - idx_q : idx_q;

  assign sharedBusCD = readyC ? slices[sel] : '0;
  assign lastC       = readyC && slice_last && pkt_last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          idx_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (xfer) begin
          if (!slice_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            pkt_d = pkt_last ? '0 : pkt_q + 1'b1;
            idx_d = '0;
            // Reload straight from the FIFO head so back-to-back words have no bubble.
            if (fifo_count != '0) begin
              pop     = 1'b1;
              shreg_d = fifo_dout;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clkC) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pkt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_bus_width_serializer.sv
// Scoreboard bench: three serializer configurations (16/8 LSB-first, 16/8 MSB-first, 32/8).
module tb_bus_width_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, ready_b, accepted_c, ready_c, accepted_d, last_c;
  logic [2:0]       ad_rand, ad_fixed;
  logic [2:0][31:0] bus_bc;
  logic [2:0][7:0]  bus_cd;
  logic [2:0][2:0]  count_c;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [1:0] dut;
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         words_in [3];
  logic [2:0] held;
  logic [8:0] held_val [3];

  bus_width_serializer #(
    .IN_W(16), .OUT_W(8), .DEPTH(4), .PKT_WORDS(4), .MSB_FIRST(0)
  ) u_dut_lsb (
    .clkC(clk), .reset(rst[0]), .sharedBusBC(bus_bc[0][15:0]), .readyB(ready_b[0]),
    .acceptedC(accepted_c[0]), .sharedBusCD(bus_cd[0]), .readyC(ready_c[0]),
    .acceptedD(accepted_d[0]), .lastC(last_c[0]), .countC(count_c[0])
  );

  bus_width_serializer #(
    .IN_W(16), .OUT_W(8), .DEPTH(4), .PKT_WORDS(4), .MSB_FIRST(1)
  ) u_dut_msb (
    .clkC(clk), .reset(rst[1]), .sharedBusBC(bus_bc[1][15:0]), .readyB(ready_b[1]),
    .acceptedC(accepted_c[1]), .sharedBusCD(bus_cd[1]), .readyC(ready_c[1]),
    .acceptedD(accepted_d[1]), .lastC(last_c[1]), .countC(count_c[1])
  );

  bus_width_serializer #(
    .IN_W(32), .OUT_W(8), .DEPTH(4), .PKT_WORDS(2), .MSB_FIRST(0)
  ) u_dut_w32 (
    .clkC(clk), .reset(rst[2]), .sharedBusBC(bus_bc[2]), .readyB(ready_b[2]),
    .acceptedC(accepted_c[2]), .sharedBusCD(bus_cd[2]), .readyC(ready_c[2]),
    .acceptedD(accepted_d[2]), .lastC(last_c[2]), .countC(count_c[2])
  );

  function automatic int ratio(input int i);
    return (i == 2) ? 4 : 2;
  endfunction

  function automatic int pkt(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic bit msb(input int i);
    return (i == 1);
  endfunction

  function automatic int pending(input int i);
    int n = 0;
    foreach (exp_q[j]) if (exp_q[j].dut == 2'(i)) n++;
    return n;
  endfunction

  function automatic logic [31:0] bp_word(input int n);
    return {16'h0, 8'(2 * n + 1), 8'(2 * n)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: a word becomes R slices in the configured order; the last slice of
  // every PKT_WORDS-th accepted word since reset carries the packet-end flag.
  task automatic expect_word(input int i, input logic [31:0] w);
    exp_t e;
    int   r, k;
    r = ratio(i);
    for (int j = 0; j < r; j++) begin
      k      = msb(i) ? r - 1 - j : j;
      e.dut  = 2'(i);
      e.data = 8'(w >> (8 * k));
      e.last = (j == r - 1) && (words_in[i] % pkt(i) == pkt(i) - 1);
      exp_q.push_back(e);
    end
    words_in[i]++;
  endtask

  task automatic purge(input int i);
    exp_t keep[$];
    foreach (exp_q[j]) if (exp_q[j].dut != 2'(i)) keep.push_back(exp_q[j]);
    exp_q = keep;
  endtask

  task automatic pop_cmp(input int i);
    int   found;
    exp_t e;
    found = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].dut == 2'(i)) begin
        found = j;
        break;
      end
    end
    if (found < 0) begin
      n_checks++;
      $display("FAIL slice%0d: got %0h last=%0b, expected no slice", i, bus_cd[i], last_c[i]);
    end else begin
      e = exp_q[found];
      exp_q.delete(found);
      chk($sformatf("slice%0d_data", i), 32'(bus_cd[i]), 32'(e.data));
      chk($sformatf("slice%0d_last", i), 32'(last_c[i]), 32'(e.last));
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        purge(i);
        words_in[i] = 0;
        held[i]     = 1'b0;
      end else begin
        if (held[i]) begin
          chk($sformatf("hold%0d", i), 32'({ready_c[i], last_c[i], bus_cd[i]}),
              32'({1'b1, held_val[i]}));
        end
        if (ready_c[i] && accepted_d[i]) pop_cmp(i);
        held[i]     = ready_c[i] && !accepted_d[i];
        held_val[i] = {last_c[i], bus_cd[i]};
        if (ready_b[i] && accepted_c[i]) expect_word(i, bus_bc[i]);
      end
    end
  end

  // Downstream acceptance driver; updates land 2 time units after the rising edge.
  initial begin
    accepted_d = '1;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        accepted_d[i] = ad_rand[i] ? 1'($urandom_range(0, 1)) : ad_fixed[i];
      end
    end
  end

  task automatic send_word(input int i, input logic [31:0] w);
    int t;
    t          = 0;
    bus_bc[i]  = w;
    ready_b[i] = 1'b1;
    @(negedge clk);
    while (!accepted_c[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!accepted_c[i]) begin
      n_checks++;
      $display("FAIL send%0d: word %0h not accepted, expected acceptance within 200 cycles",
               i, w);
    end
    @(posedge clk);
    #1;
    ready_b[i] = 1'b0;
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    @(posedge clk);
    #1;
    rst[i] = 1'b0;
    @(negedge clk);
    chk($sformatf("rst%0d_readyC", i), 32'(ready_c[i]), 0);
    chk($sformatf("rst%0d_countC", i), 32'(count_c[i]), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int i);
    int t;
    t = 0;
    while ((pending(i) != 0 || ready_c[i]) && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk($sformatf("drain%0d_pending", i), 32'(pending(i)), 0);
    chk($sformatf("drain%0d_countC", i), 32'(count_c[i]), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int i);
    ad_rand[i] = 1'b1;
    repeat (40) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_word(i, $urandom);
    end
    ad_rand[i]  = 1'b0;
    ad_fixed[i] = 1'b1;
    drain(i);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n, t, nb;
    logic done;
    rst      = '1;
    ready_b  = '0;
    bus_bc   = '0;
    ad_rand  = '0;
    ad_fixed = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d_readyC", i), 32'(ready_c[i]), 0);
      chk($sformatf("reset%0d_lastC", i), 32'(last_c[i]), 0);
      chk($sformatf("reset%0d_busCD", i), 32'(bus_cd[i]), 0);
      chk($sformatf("reset%0d_acceptedC", i), 32'(accepted_c[i]), 0);
      chk($sformatf("reset%0d_countC", i), 32'(count_c[i]), 0);
    end
    @(posedge clk);
    #1;
    rst = '0;

    // Single word: one-edge latency, two slices, then back to idle.
    bus_bc[0]  = 32'hA1B2;
    ready_b[0] = 1'b1;
    @(negedge clk);
    chk("single_acceptedC", 32'(accepted_c[0]), 1);
    @(posedge clk);
    #1;
    ready_b[0] = 1'b0;
    @(negedge clk);
    chk("single_latency", 32'(ready_c[0]), 0);
    @(negedge clk);
    chk("single_ready_a", 32'(ready_c[0]), 1);
    @(negedge clk);
    chk("single_ready_b", 32'(ready_c[0]), 1);
    @(negedge clk);
    chk("single_idle", 32'(ready_c[0]), 0);
    @(posedge clk);
    #1;

    // Full packet back-to-back: 8 consecutive slices.
    do_reset(0);
    fork
      begin
        send_word(0, 32'h1100);
        send_word(0, 32'h3322);
        send_word(0, 32'h5544);
        send_word(0, 32'h7766);
      end
      begin
        t = 0;
        n = 0;
        @(negedge clk);
        while (!ready_c[0] && t < 20) begin
          @(negedge clk);
          t++;
        end
        while (ready_c[0] && n < 20) begin
          n++;
          @(negedge clk);
        end
        chk("packet_run", 32'(n), 8);
      end
    join
    @(posedge clk);
    #1;
    drain(0);

    // Backpressure: serializer plus FIFO absorb five words, then upstream is refused.
    do_reset(0);
    ad_fixed[0] = 1'b0;
    acc         = 0;
    bus_bc[0]   = bp_word(0);
    ready_b[0]  = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (accepted_c[0]) acc++;
      @(posedge clk);
      #1;
      bus_bc[0] = bp_word(acc);
    end
    @(negedge clk);
    chk("bp_accepted_words", 32'(acc), 5);
    chk("bp_acceptedC", 32'(accepted_c[0]), 0);
    chk("bp_countC", 32'(count_c[0]), 4);
    chk("bp_busCD", 32'(bus_cd[0]), 32'h00);
    chk("bp_readyC", 32'(ready_c[0]), 1);
    @(posedge clk);
    #1;
    ready_b[0]  = 1'b0;
    ad_fixed[0] = 1'b1;
    drain(0);

    // Reset after the third slice of a packet; the next packet ends on its own 8th slice.
    do_reset(0);
    ad_fixed[0] = 1'b0;
    send_word(0, 32'h1110);
    send_word(0, 32'h1312);
    send_word(0, 32'h1514);
    send_word(0, 32'h1716);
    ad_fixed[0] = 1'b1;
    n = 0;
    t = 0;
    while (n < 3 && t < 50) begin
      @(negedge clk);
      if (ready_c[0] && accepted_d[0]) n++;
      t++;
    end
    chk("mid_bytes_before_reset", 32'(n), 3);
    @(posedge clk);
    #1;
    do_reset(0);
    fork
      begin
        send_word(0, 32'h2120);
        send_word(0, 32'h2322);
        send_word(0, 32'h2524);
        send_word(0, 32'h2726);
      end
      begin
        nb   = 0;
        t    = 0;
        done = 1'b0;
        while (!done && t < 60) begin
          @(negedge clk);
          t++;
          if (ready_c[0] && accepted_d[0]) begin
            nb++;
            if (last_c[0]) done = 1'b1;
          end
        end
        chk("new_pkt_last_slice", 32'(nb), 8);
      end
    join
    @(posedge clk);
    #1;
    drain(0);

    // MSB-first ordering.
    send_word(1, 32'hA1B2);
    t = 0;
    @(negedge clk);
    while (!ready_c[1] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("msb_first_slice", 32'(bus_cd[1]), 32'hA1);
    @(posedge clk);
    #1;
    drain(1);

    // 32-to-8 with two-word packets.
    send_word(2, 32'hDEADBEEF);
    send_word(2, 32'h01234567);
    drain(2);

    // Randomized traffic on all three configurations at once.
    fork
      run_random(0);
      run_random(1);
      run_random(2);
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
